// File: rtl/fir_dac_sender.sv
// ============================================================================
// Module   : fir_dac_sender
// Purpose  : Requantizes the 34-bit FIR output and streams it MSB-first as I2S
//            DACDAT. The same mono sample goes on both channels. Define
//            FIR_DAC_SATURATE_EN to clamp out-of-range samples; otherwise
//            they wrap.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module fir_dac_sender #(
    parameter int DW    = 16,
    parameter int SHIFT = 15
) (
    input  logic        aud_bclk,
    input  logic        rst_n,
    input  logic        aud_lrc,
    input  logic [33:0] fir_data,
    input  logic        fir_valid,
    output logic        aud_dacdat,
    output logic        tx_done,
    output logic        sample_ovf
);

    localparam int BW = (DW > 1) ? $clog2(DW) : 1;

    localparam logic signed [33:0] c_max = (34'sd1 <<< (DW - 1)) - 34'sd1;
    localparam logic signed [33:0] c_min = -(34'sd1 <<< (DW - 1));
    localparam logic [BW-1:0]      c_last    = BW'(DW - 1);
    localparam logic [BW-1:0]      c_last_m1 = BW'(DW - 2);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_PAD   = 2'd2
    } state_t;

    state_t           r_state;
    logic [BW-1:0]    r_bcnt;
    logic [DW-1:0]    r_pend;
    logic [DW-1:0]    r_cur;
    logic [DW-1:0]    r_shreg;
    logic             r_lrc_d1;

    logic signed [33:0] w_q;
    logic               w_out_of_range;
    logic [DW-1:0]      w_sample;
    logic               w_edge;
    logic               w_left;
    logic [DW-1:0]      w_slot_word;
    logic [DW-1:0]      w_shreg_nxt;

    assign w_q            = $signed(fir_data) >>> SHIFT;
    assign w_out_of_range = (w_q > c_max) || (w_q < c_min);

`ifdef FIR_DAC_SATURATE_EN
    assign w_sample = (w_q > c_max) ? c_max[DW-1:0] :
                      (w_q < c_min) ? c_min[DW-1:0] : w_q[DW-1:0];
`else
    assign w_sample = w_q[DW-1:0];
`endif

    assign w_edge = (aud_lrc != r_lrc_d1);
    assign w_left = w_edge && !aud_lrc;

    // Left slots take the newest sample (bypassing pend when it arrives on
    // the edge itself); right slots replay the word latched for the left.
    assign w_slot_word = w_left ? (fir_valid ? w_sample : r_pend) : r_cur;
    assign w_shreg_nxt = r_shreg << 1;

    always_ff @(posedge aud_bclk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_bcnt     <= '0;
            r_pend     <= '0;
            r_cur      <= '0;
            r_shreg    <= '0;
            r_lrc_d1   <= 1'b0;
            aud_dacdat <= 1'b0;
            tx_done    <= 1'b0;
            sample_ovf <= 1'b0;
        end else begin
            r_lrc_d1   <= aud_lrc;
            tx_done    <= 1'b0;
            sample_ovf <= fir_valid && w_out_of_range;

            if (fir_valid) begin
                r_pend <= w_sample;
            end

            if (w_edge) begin
                if (w_left) begin
                    r_cur <= w_slot_word;
                end
                r_shreg    <= w_slot_word;
                aud_dacdat <= w_slot_word[DW-1];
                r_bcnt     <= '0;
                tx_done    <= (DW == 1);
                r_state    <= S_SHIFT;
            end else begin
                case (r_state)
                    S_SHIFT: begin
                        if (r_bcnt == c_last) begin
                            r_state    <= S_PAD;
                            aud_dacdat <= 1'b0;
                        end else begin
                            // tx_done rises together with the LSB
                            r_bcnt     <= r_bcnt + 1'b1;
                            r_shreg    <= w_shreg_nxt;
                            aud_dacdat <= w_shreg_nxt[DW-1];
                            tx_done    <= (r_bcnt == c_last_m1);
                        end
                    end
                    default: begin
                        aud_dacdat <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

`default_nettype wire
